instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 imem_req  output  1  SHALL be a one-cycle read strobe to instruction memory.
REQ-005 imem_addr  output  32  SHALL be the byte address of the request, bits [1:0] always 2'b00.
REQ-006 imem_rvalid  input  1  SHALL mark imem_rdata valid, one or more cycles after imem_req.
REQ-007 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 inst_valid  output  1  SHALL indicate inst/inst_pc/opcode hold a valid instruction for decode.
REQ-009 inst_ready  input  1  SHALL indicate decode accepts the instruction this cycle.
REQ-010 inst  output  32  SHALL be the buffered instruction word.
REQ-011 inst_pc  output  32  SHALL be the address of inst.
REQ-012 opcode  output  7  SHALL equal inst[6:0], driving the decode controller Opcode input.
REQ-013 redirect_valid  input  1  SHALL request a control-flow change (taken branch, jal, jalr).
REQ-014 redirect_target  input  32  SHALL be the new fetch address; bits [1:0] ignored (treated as 00).
REQ-015 halt  input  1  SHALL be the decoded halt flag for the instruction currently on inst.
REQ-016 halted  output  1  SHALL be high while the block is in HALTED.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HALTED; at most one memory request outstanding.
REQ-018 In REQ, imem_req SHALL assert with imem_addr=pc only if buffer empty or inst_ready=1 this cycle, then go to WAIT; otherwise stay in REQ with imem_req=0.
REQ-019 In WAIT, imem_req SHALL be 0; on imem_rvalid with no squash, buffer SHALL load {imem_rdata, pc}, pc SHALL become pc+4, state SHALL return to REQ.
REQ-020 pc arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000).
REQ-021 Handshake: instruction transfers when inst_valid & inst_ready; inst_valid SHALL stay high and inst/inst_pc SHALL stay stable until transfer.
REQ-022 Transfer with no new load SHALL clear inst_valid next cycle; transfer and load in the same cycle SHALL keep inst_valid=1 with new contents.
REQ-023 redirect_valid (state not HALTED) SHALL set pc to {redirect_target[31:2],2'b00} and clear inst_valid next cycle.
REQ-024 redirect_valid in WAIT SHALL set a squash flag; the next imem_rvalid SHALL be discarded, squash cleared, state to REQ; redirect coinciding with imem_rvalid SHALL discard that response.
REQ-025 halt & inst_valid & inst_ready SHALL move to HALTED next cycle: inst_valid=0, imem_req=0, halted=1; any outstanding response SHALL be ignored.
REQ-026 halt and redirect_valid in the same transfer cycle: halt SHALL win.
REQ-027 HALTED SHALL be left only by reset; redirect_valid and imem_rvalid SHALL be ignored there.
REQ-028 halt with inst_valid=0 or inst_ready=0 SHALL have no effect.

Reset
REQ-029 reset SHALL force state=REQ, pc=RESET_PC, squash=0, inst_valid=0, inst=0, inst_pc=0, halted=0, imem_req=0, imem_addr=0 on the next edge.
REQ-030 reset mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid in the first post-reset cycle before any new imem_req SHALL be ignored.
REQ-031 First imem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-032 Shared package riscv_pkg SHALL hold opcode constants (R_TYPE, LW, SW, BR, IMM, JAL, JALR, HALT=7'b1111111) and the fetch state enum.
REQ-033 One sub-module fetch_buffer SHALL implement the one-entry instruction/pc holding register with valid/ready handshake.

Verification
REQ-034 Reset, RESET_PC=0, memory latency 1, inst_ready=1 -> imem_addr 0,4,8 on alternate cycles; inst_pc follows 0,4,8.
REQ-035 inst_ready=0 for 5 cycles with buffer full -> imem_req stays 0, inst/inst_pc stable; ready=1 -> fetch resumes at next pc.
REQ-036 redirect_valid, target 32'h0000_0103, during WAIT -> pending response dropped; next imem_addr=32'h0000_0100.
REQ-037 Word 32'h0000_007F (opcode 1111111) with halt=1 accepted -> halted=1 next cycle, no further imem_req for 20 cycles despite redirect_valid.
REQ-038 Redirect to 32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC then 32'h0000_0000.
REQ-039 reset asserted mid-WAIT, imem_rvalid arrives in the reset cycle -> inst_valid=0 and next imem_addr=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, fetch FSM states and a
// word-alignment helper used by the fetch unit.
package riscv_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b1111111;

    typedef enum logic [1:0] {
        FS_REQ    = 2'd0,
        FS_WAIT   = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction and its address.
// valid/ready: the entry transfers on any cycle where out_valid & out_ready.
module fetch_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);
    import riscv_pkg::*;

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // A load in the same cycle as a transfer refills the entry.
        if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read, redirect squashing,
// halt on accepted halt instruction, one-entry buffer towards decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        halted,
    output logic [1:0]  fsm_state
);
    import riscv_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         squash_q, squash_d;

    logic xfer, halt_xfer, redir, fire, buf_load;

    always_comb begin
        xfer      = inst_valid & inst_ready;
        halt_xfer = xfer & halt & (state_q != FS_HALTED);
        redir     = redirect_valid & (state_q != FS_HALTED) & ~halt_xfer;
        // No request on the cycle the halt instruction leaves, so nothing dangles.
        fire      = (state_q == FS_REQ) & (~inst_valid | inst_ready) & ~halt_xfer;

        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        buf_load = 1'b0;

        unique case (state_q)
            FS_REQ: begin
                if (halt_xfer) begin
                    state_d  = FS_HALTED;
                    squash_d = 1'b0;
                end else if (fire) begin
                    state_d  = FS_WAIT;
                    // A request to the old pc issued alongside a redirect is stale.
                    squash_d = redir;
                end
            end
            FS_WAIT: begin
                if (halt_xfer) begin
                    state_d  = FS_HALTED;
                    squash_d = 1'b0;
                end else if (imem_rvalid) begin
                    state_d  = FS_REQ;
                    squash_d = 1'b0;
                    if (!squash_q && !redir) begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end
                end else if (redir) begin
                    squash_d = 1'b1;
                end
            end
            FS_HALTED: begin
                state_d = FS_HALTED;
            end
            default: begin
                state_d = FS_REQ;
            end
        endcase

        if (redir) begin
            pc_d = word_align(redirect_target);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FS_REQ;
            pc_q     <= word_align(RESET_PC);
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
        end
    end

    fetch_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redir | halt_xfer),
        .load      (buf_load),
        .load_inst (imem_rdata),
        .load_pc   (pc_q),
        .out_ready (inst_ready),
        .out_valid (inst_valid),
        .out_inst  (inst),
        .out_pc    (inst_pc)
    );

    assign imem_req  = fire & ~reset;
    assign imem_addr = imem_req ? pc_q : 32'd0;
    assign opcode    = inst[6:0];
    assign halted    = (state_q == FS_HALTED);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of pending reads, buffer and pc,
// a responding memory with variable latency, directed scenarios then random traffic.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        halted;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .opcode          (opcode),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .fsm_state       (fsm_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: next fetch pc, one pending read (maybe stale), decode buffer.
    logic [31:0] m_pc;
    logic        m_pend, m_squash, m_valid, m_halted;
    logic [31:0] m_inst, m_ipc;

    // Memory environment.
    logic        mem_pend;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;
    logic        halt_word_en;

    // Observations of the last stepped cycle.
    logic        obs_req, obs_valid, obs_halted;
    logic [31:0] obs_addr, obs_ipc, obs_inst;
    logic [6:0]  obs_opcode;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_queue(input string name);
        check32({name, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check32(name, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        end
    endtask

    task automatic reset_model();
        m_pc = RESET_PC; m_pend = 0; m_squash = 0; m_valid = 0;
        m_inst = 0; m_ipc = 0; m_halted = 0;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
    task automatic step(input logic r, input logic rdy, input logic rd,
                        input logic [31:0] tgt, input logic hl);
        logic        exp_req, rv, xfer, hx, rd_ok;
        logic [31:0] rdat;
        rv = 1'b0;
        rdat = 32'd0;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                rv = 1'b1;
                rdat = halt_word_en ? 32'h0000_007F : mem_word(mem_addr);
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        reset = r; inst_ready = rdy; redirect_valid = rd; redirect_target = tgt;
        halt = hl; imem_rvalid = rv; imem_rdata = rdat;
        @(negedge clk);
        exp_req = !r && !m_halted && !m_pend && (!m_valid || rdy) && !(hl && m_valid && rdy);
        check32("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check32("imem_addr", imem_addr, m_pc);
        check32("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check32("inst", inst, m_inst);
            check32("inst_pc", inst_pc, m_ipc);
            check32("opcode", {25'd0, opcode}, {25'd0, m_inst[6:0]});
        end
        check32("halted", {31'd0, halted}, {31'd0, m_halted});
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = inst_valid;
        obs_ipc = inst_pc; obs_inst = inst; obs_opcode = opcode; obs_halted = halted;
        if (imem_req) begin
            mem_pend = 1'b1; mem_cnt = mem_lat; mem_addr = imem_addr;
        end
        if (r) begin
            reset_model();
        end else if (!m_halted) begin
            xfer = m_valid && rdy;
            hx = xfer && hl;
            rd_ok = rd && !hx;
            if (hx) begin
                m_halted = 1; m_valid = 0; m_pend = 0; m_squash = 0;
            end else begin
                if (xfer) m_valid = 0;
                if (exp_req) begin
                    m_pend = 1; m_squash = rd_ok;
                end else if (m_pend && rv) begin
                    m_pend = 0;
                    if (!m_squash && !rd_ok) begin
                        m_valid = 1; m_inst = rdat; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                    end
                    m_squash = 0;
                end else if (m_pend && rd_ok) begin
                    m_squash = 1;
                end
                if (rd_ok) begin
                    m_pc = tgt & 32'hFFFF_FFFC; m_valid = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int req_cnt;
        logic r, rd, hl, rdy;
        reset = 1; inst_ready = 0; redirect_valid = 0; redirect_target = 0;
        halt = 0; imem_rvalid = 0; imem_rdata = 0;
        mem_pend = 0; mem_cnt = 0; mem_lat = 1; mem_addr = 0; halt_word_en = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1, 1, 0, 0, 0);
        check32("rst_valid", {31'd0, obs_valid}, 32'd0);
        check32("rst_inst", obs_inst, 32'd0);
        check32("rst_inst_pc", obs_ipc, 32'd0);
        check32("rst_req", {31'd0, obs_req}, 32'd0);
        check32("rst_halted", {31'd0, obs_halted}, 32'd0);

        // Sequential fetch, latency 1, always ready
        exp_q = '{32'h0, 32'h4, 32'h8};
        got_q = {};
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0);
            if (obs_req) got_q.push_back(obs_addr);
        end
        check_queue("seq_addr");

        // Backpressure: buffer full holds, no requests
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            check32("bp_req", {31'd0, obs_req}, 32'd0);
            check32("bp_inst_pc", obs_ipc, 32'h8);
            check32("bp_valid", {31'd0, obs_valid}, 32'd1);
        end
        mem_lat = 2;
        step(0, 1, 0, 0, 0);
        check32("resume_addr", obs_addr, 32'hC);

        // Redirect during WAIT squashes the pending response
        step(0, 1, 1, 32'h0000_0103, 0);
        check32("sq_valid0", {31'd0, obs_valid}, 32'd0);
        step(0, 1, 0, 0, 0);
        check32("sq_valid1", {31'd0, obs_valid}, 32'd0);
        mem_lat = 1;
        step(0, 1, 0, 0, 0);
        check32("redir_req", {31'd0, obs_req}, 32'd1);
        check32("redir_addr", obs_addr, 32'h0000_0100);

        // Redirect coinciding with a response, then wrap-around
        step(0, 1, 1, 32'hFFFF_FFFC, 0);
        check32("co_valid", {31'd0, obs_valid}, 32'd0);
        step(0, 1, 0, 0, 0);
        check32("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check32("wrap_addr1", obs_addr, 32'h0000_0000);
        check32("wrap_ipc", obs_ipc, 32'hFFFF_FFFC);

        // Halt instruction accepted
        halt_word_en = 1;
        step(0, 1, 0, 0, 0);
        halt_word_en = 0;
        step(0, 1, 0, 0, 1);
        check32("halt_opcode", {25'd0, obs_opcode}, 32'h7F);
        check32("halt_inst", obs_inst, 32'h0000_007F);
        step(0, 1, 0, 0, 0);
        check32("halted_now", {31'd0, obs_halted}, 32'd1);
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1, $urandom, 1'($urandom_range(0, 1)));
            if (obs_req) req_cnt++;
        end
        check32("halt_req_cnt", 32'(req_cnt), 32'd0);
        check32("halt_stays", {31'd0, obs_halted}, 32'd1);

        // Reset mid-WAIT with the response landing in the reset cycle
        mem_lat = 2;
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check32("rw_addr0", obs_addr, RESET_PC);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check32("rw_valid", {31'd0, obs_valid}, 32'd0);
        check32("rw_req", {31'd0, obs_req}, 32'd1);
        check32("rw_addr1", obs_addr, RESET_PC);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            mem_lat = $urandom_range(1, 3);
            r   = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 15) == 0);
            hl  = ($urandom_range(0, 24) == 0);
            step(r, rdy, rd, $urandom, hl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
